boot_load_ctrl: RTL and testbench
=================================

Name: boot_load_ctrl

Overview:
- Boot/reload sequencer for the 16-bit RISC processor's memory.
- Holds the processor in reset while it receives a program image over an 8-bit valid/ready byte stream: a 16-bit length header followed by data words.
- Writes each assembled word into the shared single-port memory, then releases the processor.
- Arbitrates the memory bus: the loader owns it during load; the processor owns it in RUN.

Parameters:
BASE_ADDR, 16'h0000, memory address of the first loaded word.
MAX_WORDS, 256, largest legal length header; larger values are an error.
RST_HOLD, 4, cycles cpu_reset stays high after the last write before release (≥1).

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-low reset.
start  in  1  one-cycle reload request; honoured only in RUN or ERR.
rx_data  in  8  stream byte.
rx_valid  in  1  rx_data valid.
rx_ready  out  1  loader accepts a byte; transfer = rx_valid & rx_ready at a rising edge.
cpu_Address  in  16  processor memory address.
cpu_D_out  in  16  processor write data.
cpu_mw_en  in  1  processor memory write enable.
mem_Address  out  16  memory address.
mem_D_in  out  16  memory write data.
mem_we  out  1  memory write enable.
cpu_reset  out  1  active-high processor reset.
done  out  1  high while in RUN.
err  out  1  sticky length error; high while in ERR.

Behaviour:
- States: LEN_HI, LEN_LO, DAT_HI, DAT_LO, WRITE, HOLD, RUN, ERR.
- Reset (reset=0, asynchronous): state=LEN_HI, len=0, index=0, hold_cnt=0, data regs=0, mem_we=0, cpu_reset=1, done=0, err=0. No byte is sampled while reset=0.
- rx_ready=1 only in LEN_HI, LEN_LO, DAT_HI, DAT_LO. It is state-decoded, with no combinational path from rx_valid.
- LEN_HI: on transfer, len[15:8]=byte, go to LEN_LO.
- LEN_LO: on transfer, len[7:0]=byte. Next state is decided from the full {hi,byte} value:
  - value==0 → HOLD, with no memory writes.
  - value>MAX_WORDS → ERR.
  - otherwise → DAT_HI with index=0.
- DAT_HI: on transfer, word[15:8]=byte, go to DAT_LO.
- DAT_LO: on transfer, word[7:0]=byte, go to WRITE.
- WRITE: exactly one cycle with mem_we=1, mem_Address=(BASE_ADDR+index) mod 2^16, mem_D_in=word. Then index++.
  - If index was len-1 → HOLD (hold_cnt=0).
  - Otherwise → DAT_HI.
- Byte order is big-endian for both header and data.
- HOLD: hold_cnt increments each cycle. When hold_cnt==RST_HOLD-1 → RUN. cpu_reset stays 1 throughout.
- RUN: cpu_reset=0, done=1.
  - Bus pass-through is combinational: mem_Address=cpu_Address, mem_D_in=cpu_D_out, mem_we=cpu_mw_en.
  - start=1 → LEN_HI: cpu_reset=1 and done=0 from the next edge, len/index cleared.
- ERR: err=1, cpu_reset=1, rx_ready=0. start=1 → LEN_HI, err cleared.
- All non-RUN states except WRITE: mem_we=0, and mem_Address/mem_D_in hold their last loader values. cpu_* inputs are ignored.
- start is ignored in LEN_HI..HOLD. A start coinciding with a stream byte in RUN means the byte is not accepted (rx_ready=0 in RUN).
- Address wrap: BASE_ADDR+index overflows modulo 2^16 with no error.
- cpu_reset, done and err are registered outputs. mem_* are muxed by registered state only.
- rx_valid held with rx_ready=0 (WRITE/HOLD/RUN/ERR): the byte is not consumed and is accepted later in a receive state.

Test Plan:
- BASE_ADDR=0, stream 00 03 12 34 AB CD 00 01 → single-cycle mem_we at addr 0/1/2 with data 1234/ABCD/0001. cpu_reset stays 1 for exactly 4 cycles after the third write, then 0, done=1.
- Stream 00 00 → no mem_we pulse. HOLD for 4 cycles, then RUN, done=1.
- Stream 01 01 (257 > 256) → err=1, cpu_reset=1, rx_ready=0, no writes. start pulse → err=0, LEN_HI; a new stream 00 01 BE EF writes BEEF at addr 0.
- rx_valid toggled every other cycle, and held high across WRITE → every byte consumed exactly once, rx_ready=0 during WRITE, correct words written.
- In RUN: cpu_Address=0040, cpu_D_out=5555, cpu_mw_en=1 → mem outputs equal them in the same cycle. start pulse → cpu_reset=1 and mem_we=0 from the next edge.
- Assert reset after 2 of 3 words → all outputs at reset values immediately. After release, a new header 00 01 restarts the load at BASE_ADDR. BASE_ADDR=FFFF with len=2 → writes to FFFF then 0000.

Source files
------------

// File: rtl/boot_load_ctrl.sv
// Boot/reload sequencer: receives a length-prefixed big-endian word image over a byte stream,
// writes it to the shared memory while holding the CPU in reset, then hands the bus to the CPU.
module boot_load_ctrl #(
  parameter logic [15:0] BaseAddr = 16'h0000,
  parameter int unsigned MaxWords = 256,
  parameter int unsigned RstHold  = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  input  logic [15:0] cpu_address_i,
  input  logic [15:0] cpu_d_out_i,
  input  logic        cpu_mw_en_i,
  output logic [15:0] mem_address_o,
  output logic [15:0] mem_d_in_o,
  output logic        mem_we_o,
  output logic        cpu_reset_o,
  output logic        done_o,
  output logic        err_o
);

  localparam int unsigned HoldW = (RstHold > 1) ? $clog2(RstHold) : 1;
  localparam logic [HoldW-1:0] HoldLast = HoldW'(RstHold - 1);
  localparam logic [16:0] MaxLen = 17'(MaxWords);

  typedef enum logic [2:0] {
    StLenHi,
    StLenLo,
    StDatHi,
    StDatLo,
    StWrite,
    StHold,
    StRun,
    StErr
  } state_e;

  state_e           state_q, state_d;
  logic [15:0]      len_q, len_d;
  logic [15:0]      index_q, index_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]       hi_q, hi_d;
  logic [15:0]      addr_q, addr_d;
  logic [15:0]      data_q, data_d;
  logic             cpu_reset_q, done_q, err_q;

  logic        rx_fire;
  logic [15:0] len_full;
  logic        last_word;

  assign rx_fire   = rx_valid_i & rx_ready_o;
  assign len_full  = {len_q[15:8], rx_data_i};
  assign last_word = (index_q == (len_q - 16'd1));

  // State register; status outputs are registered from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StLenHi;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= (state_d != StRun);
      done_q      <= (state_d == StRun);
      err_q       <= (state_d == StErr);
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StLenHi: if (rx_fire) state_d = StLenLo;
      StLenLo: begin
        if (rx_fire) begin
          if (len_full == 16'd0) begin
            state_d = StHold;
          end else if ({1'b0, len_full} > MaxLen) begin
            state_d = StErr;
          end else begin
            state_d = StDatHi;
          end
        end
      end
      StDatHi: if (rx_fire) state_d = StDatLo;
      StDatLo: if (rx_fire) state_d = StWrite;
      StWrite: state_d = last_word ? StHold : StDatHi;
      StHold:  if (hold_cnt_q == HoldLast) state_d = StRun;
      StRun:   if (start_i) state_d = StLenHi;
      StErr:   if (start_i) state_d = StLenHi;
      default: state_d = StLenHi;
    endcase
  end

  // Loader datapath. addr/data are latched on the last data byte so that the memory bus
  // keeps showing the previous loader values until the write cycle itself.
  always_comb begin
    len_d      = len_q;
    index_d    = index_q;
    hold_cnt_d = '0;
    hi_d       = hi_q;
    addr_d     = addr_q;
    data_d     = data_q;
    unique case (state_q)
      StLenHi: if (rx_fire) len_d[15:8] = rx_data_i;
      StLenLo: begin
        if (rx_fire) begin
          len_d[7:0] = rx_data_i;
          index_d    = '0;
        end
      end
      StDatHi: if (rx_fire) hi_d = rx_data_i;
      StDatLo: begin
        if (rx_fire) begin
          addr_d = BaseAddr + index_q;
          data_d = {hi_q, rx_data_i};
        end
      end
      StWrite: index_d = index_q + 16'd1;
      StHold:  hold_cnt_d = hold_cnt_q + 1'b1;
      StRun, StErr: begin
        if (start_i) begin
          len_d   = '0;
          index_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      len_q      <= '0;
      index_q    <= '0;
      hold_cnt_q <= '0;
      hi_q       <= '0;
      addr_q     <= '0;
      data_q     <= '0;
    end else begin
      len_q      <= len_d;
      index_q    <= index_d;
      hold_cnt_q <= hold_cnt_d;
      hi_q       <= hi_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
    end
  end

  // Bus ownership and handshake depend on registered state only.
  always_comb begin
    rx_ready_o    = 1'b0;
    mem_address_o = addr_q;
    mem_d_in_o    = data_q;
    mem_we_o      = 1'b0;
    unique case (state_q)
      StLenHi, StLenLo, StDatHi, StDatLo: rx_ready_o = 1'b1;
      StWrite: mem_we_o = 1'b1;
      StRun: begin
        mem_address_o = cpu_address_i;
        mem_d_in_o    = cpu_d_out_i;
        mem_we_o      = cpu_mw_en_i;
      end
      default: ;
    endcase
  end

  assign cpu_reset_o = cpu_reset_q;
  assign done_o      = done_q;
  assign err_o       = err_q;

  a_no_rx_in_write: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StWrite) |-> !rx_ready_o);
  a_write_single: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StWrite) |=> (state_q != StWrite));
  a_done_excl: assert property (@(posedge clk_i) disable iff (!rst_ni)
    done_o |-> (!cpu_reset_o && !err_o));

endmodule

// File: tb/tb_boot_load_ctrl.sv
// Self-checking bench for boot_load_ctrl: directed table loads, bus pass-through table,
// mid-load reset and randomized streams checked against a stream-level reference model.
module tb_boot_load_ctrl;

  localparam int unsigned RstHold  = 4;
  localparam int unsigned MaxWords = 256;

  typedef logic [7:0]  byte_q_t [$];
  typedef logic [31:0] wr_q_t [$];

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic [15:0] cpu_address = 16'h0;
  logic [15:0] cpu_d_out = 16'h0;
  logic        cpu_mw_en = 1'b0;

  logic        rx_ready_a, mem_we_a, cpu_reset_a, done_a, err_a;
  logic [15:0] mem_address_a, mem_d_in_a;
  logic        rx_ready_b, mem_we_b, cpu_reset_b, done_b, err_b;
  logic [15:0] mem_address_b, mem_d_in_b;

  always #5 clk = ~clk;

  boot_load_ctrl #(.BaseAddr(16'h0000), .MaxWords(MaxWords), .RstHold(RstHold)) dut_a (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready_a), .cpu_address_i(cpu_address), .cpu_d_out_i(cpu_d_out),
    .cpu_mw_en_i(cpu_mw_en), .mem_address_o(mem_address_a), .mem_d_in_o(mem_d_in_a),
    .mem_we_o(mem_we_a), .cpu_reset_o(cpu_reset_a), .done_o(done_a), .err_o(err_a)
  );

  boot_load_ctrl #(.BaseAddr(16'hFFFF), .MaxWords(MaxWords), .RstHold(RstHold)) dut_b (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .rx_data_i(rx_data), .rx_valid_i(rx_valid),
    .rx_ready_o(rx_ready_b), .cpu_address_i(cpu_address), .cpu_d_out_i(cpu_d_out),
    .cpu_mw_en_i(cpu_mw_en), .mem_address_o(mem_address_b), .mem_d_in_o(mem_d_in_b),
    .mem_we_o(mem_we_b), .cpu_reset_o(cpu_reset_b), .done_o(done_b), .err_o(err_b)
  );

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  int last_evt = -1;
  int run_cyc = -1;
  int err_cyc = -1;
  int viol = 0;
  logic prev_we = 1'b0;
  byte_q_t got;
  wr_q_t wa, wb;
  logic [15:0] last_a = 16'h0, last_b = 16'h0, last_d = 16'h0;

  typedef struct {
    int          n;
    logic [63:0] bytes;
    int          mode;
    logic        exp_err;
    int          exp_writes;
  } load_vec_t;

  typedef struct {
    logic [15:0] a, d;
    logic        we;
    logic [15:0] ea, ed;
    logic        ewe;
  } run_vec_t;

  load_vec_t lv[5];
  run_vec_t  rv[4];

  always @(posedge clk) cyc++;

  // Passive monitor: records accepted bytes and loader-phase writes.
  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_valid && rx_ready_a) begin
        got.push_back(rx_data);
        last_evt = cyc;
      end
      if (mem_we_a && cpu_reset_a) begin
        wa.push_back({mem_address_a, mem_d_in_a});
        last_evt = cyc;
        if (rx_ready_a || prev_we) viol++;
      end
      if (mem_we_b && cpu_reset_b) wb.push_back({mem_address_b, mem_d_in_b});
      prev_we = mem_we_a && cpu_reset_a;
      if ({rx_ready_a, done_a, err_a, cpu_reset_a} != {rx_ready_b, done_b, err_b, cpu_reset_b})
        viol++;
      if (!cpu_reset_a && run_cyc < 0) run_cyc = cyc;
      if (err_a && err_cyc < 0) err_cyc = cyc;
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: what a stream should produce, from the header/word rules alone.
  function automatic void model(input byte_q_t s, input logic [15:0] base, output wr_q_t w,
                                output int ncons, output int is_err);
    int len;
    len = {s[0], s[1]};
    w = {};
    if (len > int'(MaxWords)) begin
      ncons = 2;
      is_err = 1;
      return;
    end
    ncons = 2 + 2 * len;
    is_err = 0;
    for (int i = 0; i < len; i++) begin
      logic [15:0] a;
      a = base + 16'(i);
      w.push_back({a, s[2+2*i], s[3+2*i]});
    end
  endfunction

  task automatic send(input byte_q_t s, input int mode);
    int idx = 0;
    int budget = 0;
    logic v, rdy;
    while (idx < s.size() && budget < 5000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (budget % 2 == 0);
        default: v = 1'($urandom_range(0, 1));
      endcase
      rx_valid    = v;
      rx_data     = v ? s[idx] : 8'($urandom);
      cpu_address = 16'($urandom);
      cpu_d_out   = 16'($urandom);
      cpu_mw_en   = 1'($urandom);
      start       = ($urandom_range(0, 7) == 0);
      rdy = rx_ready_a;
      step();
      if (v && rdy) idx++;
      budget++;
    end
    rx_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic run_load(input string nm, input byte_q_t s, input int mode);
    wr_q_t ea, eb;
    int ncons, is_err, waitc, nbad;
    model(s, 16'h0000, ea, ncons, is_err);
    model(s, 16'hFFFF, eb, ncons, is_err);
    got.delete(); wa.delete(); wb.delete();
    viol = 0; run_cyc = -1; err_cyc = -1; last_evt = -1;
    send(s, mode);
    waitc = 0;
    while (!(done_a || err_a) && waitc < 60) begin
      step();
      waitc++;
    end
    @(negedge clk);
    @(posedge clk);
    #1;
    chk($sformatf("%s status", nm), {done_a, err_a, cpu_reset_a, rx_ready_a},
        (is_err != 0) ? 4'b0110 : 4'b1000);
    chk($sformatf("%s consumed", nm), got.size(), ncons);
    nbad = 0;
    for (int i = 0; i < got.size() && i < s.size(); i++) if (got[i] !== s[i]) nbad++;
    chk($sformatf("%s byte order", nm), nbad, 0);
    chk($sformatf("%s nwrites_a", nm), wa.size(), ea.size());
    chk($sformatf("%s nwrites_b", nm), wb.size(), eb.size());
    for (int i = 0; i < wa.size() && i < ea.size(); i++)
      chk($sformatf("%s write_a[%0d]", nm, i), wa[i], ea[i]);
    for (int i = 0; i < wb.size() && i < eb.size(); i++)
      chk($sformatf("%s write_b[%0d]", nm, i), wb[i], eb[i]);
    if (is_err != 0) chk($sformatf("%s err latency", nm), err_cyc - last_evt, 1);
    else chk($sformatf("%s hold length", nm), run_cyc - last_evt, RstHold + 1);
    chk($sformatf("%s protocol", nm), viol, 0);
    if (ea.size() > 0) begin
      last_a = ea[ea.size()-1][31:16];
      last_b = eb[eb.size()-1][31:16];
      last_d = ea[ea.size()-1][15:0];
    end
  endtask

  task automatic do_start(input string nm);
    cpu_address = 16'h0040;
    cpu_d_out   = 16'h5555;
    cpu_mw_en   = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk($sformatf("%s flags", nm), {cpu_reset_a, done_a, err_a, rx_ready_a, mem_we_a},
        5'b10010);
    chk($sformatf("%s loader bus a", nm), {mem_address_a, mem_d_in_a}, {last_a, last_d});
    chk($sformatf("%s loader bus b", nm), {mem_address_b, mem_we_b}, {last_b, 1'b0});
  endtask

  task automatic run_table();
    for (int k = 0; k < 4; k++) begin
      cpu_address = rv[k].a;
      cpu_d_out   = rv[k].d;
      cpu_mw_en   = rv[k].we;
      #1;
      chk($sformatf("run mux a%0d", k), {mem_address_a, mem_d_in_a, mem_we_a},
          {rv[k].ea, rv[k].ed, rv[k].ewe});
      chk($sformatf("run mux b%0d", k), {mem_address_b, mem_d_in_b, mem_we_b},
          {rv[k].ea, rv[k].ed, rv[k].ewe});
      step();
    end
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    byte_q_t s;
    lv[0] = '{8, 64'h0003_1234_ABCD_0001, 0, 1'b0, 3};
    lv[1] = '{8, 64'h0003_1234_ABCD_0001, 1, 1'b0, 3};
    lv[2] = '{2, 64'h0000_0000_0000_0000, 0, 1'b0, 0};
    lv[3] = '{2, 64'h0101_0000_0000_0000, 0, 1'b1, 0};
    lv[4] = '{4, 64'h0001_BEEF_0000_0000, 2, 1'b0, 1};
    rv[0] = '{16'h0040, 16'h5555, 1'b1, 16'h0040, 16'h5555, 1'b1};
    rv[1] = '{16'hFFFF, 16'h0000, 1'b0, 16'hFFFF, 16'h0000, 1'b0};
    rv[2] = '{16'h1234, 16'hABCD, 1'b1, 16'h1234, 16'hABCD, 1'b1};
    rv[3] = '{16'h0000, 16'hFFFF, 1'b0, 16'h0000, 16'hFFFF, 1'b0};

    // Byte presented during reset must not be taken.
    rx_valid = 1'b1;
    rx_data  = 8'hFF;
    repeat (2) @(posedge clk);
    #1;
    chk("reset flags", {cpu_reset_a, done_a, err_a, mem_we_a, rx_ready_a}, 5'b10001);
    chk("reset bus", {mem_address_a, mem_d_in_a}, 32'h0);
    #2;
    rst_n = 1'b1;
    rx_valid = 1'b0;
    step();

    for (int i = 0; i < 5; i++) begin
      s = {};
      for (int k = 0; k < lv[i].n; k++) s.push_back(lv[i].bytes[63-8*k -: 8]);
      if (i > 0) do_start($sformatf("start%0d", i));
      run_load($sformatf("load%0d", i), s, lv[i].mode);
      chk($sformatf("load%0d err", i), err_a, lv[i].exp_err);
      chk($sformatf("load%0d writes", i), wa.size(), lv[i].exp_writes);
      if (i == 0) run_table();
    end

    // Reset in the middle of a three-word load.
    do_start("start mid");
    got.delete(); wa.delete(); wb.delete();
    s = {8'h00, 8'h03, 8'h11, 8'h11, 8'h22, 8'h22};
    send(s, 0);
    step();
    chk("midload writes", wa.size(), 2);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async reset flags", {cpu_reset_a, done_a, err_a, mem_we_a, rx_ready_a}, 5'b10001);
    chk("async reset bus", {mem_address_a, mem_d_in_a, mem_address_b}, 48'h0);
    rst_n = 1'b1;
    last_a = 16'h0; last_b = 16'h0; last_d = 16'h0;
    step();
    run_load("restart", '{8'h00, 8'h01, 8'h12, 8'h34}, 0);

    for (int t = 0; t < 12; t++) begin
      int len, sel;
      sel = (t < 4) ? t : int'($urandom_range(0, 6));
      case (sel)
        0:       len = int'(MaxWords);
        1:       len = int'(MaxWords) + 1;
        2:       len = 0;
        3:       len = 1;
        4:       len = int'($urandom_range(257, 65535));
        default: len = int'($urandom_range(2, 40));
      endcase
      s = {};
      s.push_back(8'(len >> 8));
      s.push_back(8'(len));
      if (len >= 1 && len <= int'(MaxWords))
        for (int k = 0; k < 2 * len; k++) s.push_back(8'($urandom));
      do_start($sformatf("rstart%0d", t));
      run_load($sformatf("rand%0d", t), s, int'($urandom_range(0, 2)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
